// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back port arbiter.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   wb_req_t          : one pending register write {rd, data}
//   wbarb_state_t     : arbitration state (NORMAL / FORCE)
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wbarb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding buffered MDU results, with two parallel
// destination-register match ports for the hazard unit.
//   clk, reset            : clock, asynchronous active-low reset (flushes entries)
//   push, push_data       : enqueue (ignored when full)
//   pop                   : dequeue head (ignored when empty)
//   head                  : oldest entry
//   full, empty           : occupancy flags
//   almost_full           : exactly one free slot left
//   query_a/b, hit_a/b    : rd match against any valid entry, never for x0
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  input  logic [REG_ADDR_W-1:0] query_a,
  input  logic [REG_ADDR_W-1:0] query_b,
  output logic                  hit_a,
  output logic                  hit_b
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Slot valid bits and pointers; push and pop never target the same slot
  // because that would require the FIFO to be both full and empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Payload storage, qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Occupancy and destination-register matches.
  always_comb begin
    occ   = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ = occ + CNT_W'(valid_q[i]);
      if (valid_q[i] && (mem_q[i].rd == query_a)) hit_a = 1'b1;
      if (valid_q[i] && (mem_q[i].rd == query_b)) hit_b = 1'b1;
    end
    hit_a = hit_a && (query_a != '0);
    hit_b = hit_b && (query_b != '0);
  end

  assign full        = (occ == CNT_W'(DEPTH));
  assign empty       = (occ == '0);
  assign almost_full = (occ == CNT_W'(DEPTH - 1));
  assign head        = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage and out-of-band MDU results. MDU results are bypassed when the port
// is free, otherwise buffered; the pipeline has priority until the buffered
// head has lost MAX_WAIT times (or the buffer fills), then one forced drain
// stalls the pipeline for a cycle.
//   clk, reset                 : clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_data  : WB stage write request
//   pipe_stall                 : WB write not taken this cycle
//   mdu_valid/mdu_rd/mdu_data  : MDU result, accepted when mdu_ready
//   rf_we/rf_waddr/rf_wdata    : register-file write port
//   query_rs1/2, hit_rs1/2     : buffered-write hazard lookup
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  output logic                  mdu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] query_rs1,
  input  logic [REG_ADDR_W-1:0] query_rs2,
  output logic                  hit_rs1,
  output logic                  hit_rs2
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  wbarb_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  wb_req_t fifo_head;
  wb_req_t mdu_req;
  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_almost_full;
  logic    pipe_req;
  logic    mdu_keep;
  logic    full_next;

  assign mdu_req = '{rd: mdu_rd, data: mdu_data};

  wb_result_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_data   (mdu_req),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full),
    .query_a     (query_rs1),
    .query_b     (query_rs2),
    .hit_a       (hit_rs1),
    .hit_b       (hit_rs2)
  );

  // State register and anti-starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Grant selection, FIFO control and next state.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pipe_stall = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    full_next  = 1'b0;

    pipe_req  = pipe_we && (pipe_rd != '0);
    mdu_ready = !fifo_full;
    // Results for x0 complete the handshake but are dropped.
    mdu_keep  = mdu_valid && !fifo_full && (mdu_rd != '0);

    unique case (state_q)
      FORCE: begin
        rf_we      = 1'b1;
        rf_waddr   = fifo_head.rd;
        rf_wdata   = fifo_head.data;
        fifo_pop   = 1'b1;
        fifo_push  = mdu_keep;
        pipe_stall = pipe_req;
        wait_d     = '0;
        state_d    = NORMAL;
      end
      NORMAL: begin
        if (fifo_empty) begin
          if (pipe_req) begin
            rf_we     = 1'b1;
            rf_waddr  = pipe_rd;
            rf_wdata  = pipe_data;
            fifo_push = mdu_keep;
          end else if (mdu_keep) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_rd;
            rf_wdata = mdu_data;
          end
        end else begin
          // New MDU results queue behind the head to keep MDU write order.
          fifo_push = mdu_keep;
          if (pipe_req) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
            wait_d   = wait_q + WAIT_W'(1);
          end else begin
            rf_we    = 1'b1;
            rf_waddr = fifo_head.rd;
            rf_wdata = fifo_head.data;
            fifo_pop = 1'b1;
            wait_d   = '0;
          end
        end
        full_next = (fifo_full && !fifo_pop) ||
                    (fifo_almost_full && fifo_push && !fifo_pop);
        if ((wait_d == WAIT_W'(MAX_WAIT)) || full_next) begin
          state_d = FORCE;
        end
      end
    endcase
  end

endmodule
